// File: rtl/dma_controller.sv
// Cycle-stealing memory-to-memory byte copy engine on the shared dMemIO bus.
// The CPU programs it through eight IO registers; the CPU always wins the bus.
module dma_controller #(
  parameter logic [7:0] BASE_ADDR = 8'h80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cfg_address,
  input  logic [7:0]  cfg_din,
  input  logic        cfg_w_en,
  input  logic        cfg_r_en,
  output logic [7:0]  cfg_dout,
  input  logic        cpu_bus_busy,
  output logic        bus_grant,
  output logic [15:0] dma_address,
  output logic [7:0]  dma_dout,
  output logic        dma_w_en,
  output logic        dma_r_en,
  input  logic [7:0]  dma_din,
  output logic        done_flag,
  input  logic        done_flag_clr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    RWAIT = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t      state_q;
  logic [15:0] src_q;
  logic [15:0] dst_q;
  logic [15:0] len_q;
  logic [7:0]  data_q;
  logic [7:0]  dout_q;
  logic        done_q;

  logic        sel_s;
  logic [2:0]  off_s;
  logic        start_s;
  logic        abort_s;
  logic        busy_s;
  logic        wr_free_s;
  logic        done_set_s;
  logic [15:0] len_dec_s;
  logic [7:0]  rd_data_d;

  assign sel_s     = (cfg_address[7:3] == BASE_ADDR[7:3]);
  assign off_s     = cfg_address[2:0];
  assign start_s   = cfg_w_en && sel_s && (off_s == 3'd6) && cfg_din[0];
  assign abort_s   = cfg_w_en && sel_s && (off_s == 3'd6) && cfg_din[1];
  assign busy_s    = (state_q != IDLE);
  assign wr_free_s = (state_q == WRITE) && !cpu_bus_busy;
  assign len_dec_s = len_q - 16'd1;

  // An aborted write strobe still goes out but is never counted as completion.
  assign done_set_s = ((state_q == IDLE) && start_s && !abort_s && (len_q == 16'd0)) ||
                      (wr_free_s && !abort_s && (len_dec_s == 16'd0));

  assign cfg_dout  = dout_q;
  assign done_flag = done_q;

  // Bus strobes follow state and CPU activity directly so the CPU is never delayed.
  always_comb begin
    bus_grant   = 1'b0;
    dma_r_en    = 1'b0;
    dma_w_en    = 1'b0;
    dma_address = 16'h0000;
    dma_dout    = 8'h00;
    if ((state_q == READ) && !cpu_bus_busy) begin
      bus_grant   = 1'b1;
      dma_r_en    = 1'b1;
      dma_address = src_q;
    end else if (wr_free_s) begin
      bus_grant   = 1'b1;
      dma_w_en    = 1'b1;
      dma_address = dst_q;
      dma_dout    = data_q;
    end else begin
      bus_grant   = 1'b0;
    end
  end

  // Register read-back mux; pointers and count read back live.
  always_comb begin
    rd_data_d = 8'h00;
    case (off_s)
      3'd0:    rd_data_d = src_q[7:0];
      3'd1:    rd_data_d = src_q[15:8];
      3'd2:    rd_data_d = dst_q[7:0];
      3'd3:    rd_data_d = dst_q[15:8];
      3'd4:    rd_data_d = len_q[7:0];
      3'd5:    rd_data_d = len_q[15:8];
      3'd7:    rd_data_d = {6'b000000, done_q, busy_s};
      default: rd_data_d = 8'h00;
    endcase
  end

  // Transfer FSM, configuration registers, read data and completion flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= 16'h0000;
      dst_q   <= 16'h0000;
      len_q   <= 16'h0000;
      data_q  <= 8'h00;
      dout_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      if (cfg_r_en && sel_s) begin
        dout_q <= rd_data_d;
      end
      if (done_set_s) begin
        done_q <= 1'b1;
      end else if (done_flag_clr) begin
        done_q <= 1'b0;
      end
      if (cfg_w_en && sel_s && !busy_s) begin
        case (off_s)
          3'd0:    src_q[7:0]  <= cfg_din;
          3'd1:    src_q[15:8] <= cfg_din;
          3'd2:    dst_q[7:0]  <= cfg_din;
          3'd3:    dst_q[15:8] <= cfg_din;
          3'd4:    len_q[7:0]  <= cfg_din;
          3'd5:    len_q[15:8] <= cfg_din;
          default: ;
        endcase
      end
      case (state_q)
        IDLE: begin
          if (start_s && !abort_s && (len_q != 16'd0)) begin
            state_q <= READ;
          end
        end
        READ: begin
          if (abort_s) begin
            state_q <= IDLE;
          end else if (!cpu_bus_busy) begin
            state_q <= RWAIT;
          end
        end
        RWAIT: begin
          data_q  <= dma_din;
          state_q <= abort_s ? IDLE : WRITE;
        end
        WRITE: begin
          if (abort_s) begin
            state_q <= IDLE;
          end else if (!cpu_bus_busy) begin
            src_q   <= src_q + 16'd1;
            dst_q   <= dst_q + 16'd1;
            len_q   <= len_dec_s;
            state_q <= (len_dec_s == 16'd0) ? IDLE : READ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller: expected bus transactions are queued when a
// transfer is programmed and popped as the DUT strobes the bus.
module tb_dma_controller;

  localparam logic [7:0] BASE = 8'h80;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cfg_address;
  logic [7:0]  cfg_din;
  logic        cfg_w_en;
  logic        cfg_r_en;
  logic [7:0]  cfg_dout;
  logic        cpu_bus_busy;
  logic        bus_grant;
  logic [15:0] dma_address;
  logic [7:0]  dma_dout;
  logic        dma_w_en;
  logic        dma_r_en;
  logic [7:0]  dma_din;
  logic        done_flag;
  logic        done_flag_clr;

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [7:0]  d;
  } txn_t;

  txn_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        rd_pend = 1'b0;
  logic [7:0]  rd_data = 8'h00;

  dma_controller #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .cfg_address(cfg_address), .cfg_din(cfg_din), .cfg_w_en(cfg_w_en), .cfg_r_en(cfg_r_en),
    .cfg_dout(cfg_dout), .cpu_bus_busy(cpu_bus_busy), .bus_grant(bus_grant),
    .dma_address(dma_address), .dma_dout(dma_dout), .dma_w_en(dma_w_en), .dma_r_en(dma_r_en),
    .dma_din(dma_din), .done_flag(done_flag), .done_flag_clr(done_flag_clr)
  );

  always #5 clk = ~clk;

  // Source memory contents as seen by the bench's bus map.
  function automatic logic [7:0] mem_f(input logic [15:0] a);
    logic [7:0] lo3;
    lo3 = a[7:0] * 8'd3;
    return lo3 ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic w, input logic [15:0] a);
    txn_t t;
    t.w = w;
    t.a = a;
    t.d = 8'h00;
    exp_q.push_back(t);
  endtask

  task automatic push_copy(input logic [15:0] s, input logic [15:0] d);
    txn_t t;
    push(1'b0, s);
    t.w = 1'b1;
    t.a = d;
    t.d = mem_f(s);
    exp_q.push_back(t);
  endtask

  // One clock: check bus activity mid-cycle, then return read data after the edge.
  task automatic cyc();
    txn_t t;
    @(negedge clk);
    if (dma_r_en || dma_w_en) begin
      chk("grant", {31'd0, bus_grant}, 32'd1);
      chk("cpu_free", {31'd0, cpu_bus_busy}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("spurious_strobe", {30'd0, dma_w_en, dma_r_en}, 32'd0);
      end else begin
        t = exp_q.pop_front();
        chk("strobe_kind", {30'd0, dma_w_en, dma_r_en}, t.w ? 32'd2 : 32'd1);
        chk("addr", {16'd0, dma_address}, {16'd0, t.a});
        if (t.w) chk("wdata", {24'd0, dma_dout}, {24'd0, t.d});
        else begin
          rd_pend = 1'b1;
          rd_data = mem_f(dma_address);
        end
      end
    end else begin
      chk("idle_grant", {31'd0, bus_grant}, 32'd0);
    end
    @(posedge clk);
    #1;
    dma_din = rd_pend ? rd_data : 8'hEE;
    rd_pend = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    cfg_address = BASE + {5'd0, off};
    cfg_din = d;
    cfg_w_en = 1'b1;
    cyc();
    cfg_w_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] off, input logic [7:0] exp);
    cfg_address = BASE + {5'd0, off};
    cfg_r_en = 1'b1;
    cyc();
    cfg_r_en = 1'b0;
    chk(tag, {24'd0, cfg_dout}, {24'd0, exp});
  endtask

  task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    wr(3'd0, s[7:0]); wr(3'd1, s[15:8]);
    wr(3'd2, d[7:0]); wr(3'd3, d[15:8]);
    wr(3'd4, n[7:0]); wr(3'd5, n[15:8]);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done_flag && n < 60) begin
      cyc();
      n++;
    end
    chk(tag, {31'd0, done_flag}, 32'd1);
  endtask

  task automatic clear_done();
    done_flag_clr = 1'b1;
    cyc();
    done_flag_clr = 1'b0;
    chk("done_clear", {31'd0, done_flag}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    cfg_address = 8'h00; cfg_din = 8'h00; cfg_w_en = 1'b0; cfg_r_en = 1'b0;
    cpu_bus_busy = 1'b0; dma_din = 8'h00; done_flag_clr = 1'b0;
    #1;
    chk("rst_outputs", {bus_grant, dma_r_en, dma_w_en, done_flag, dma_address, dma_dout, 4'd0},
        32'd0);
    chk("rst_cfg_dout", {24'd0, cfg_dout}, 32'd0);
    cyc(); cyc();
    rst = 1'b0;
    rd("rst_status", 3'd7, 8'h00);
    rd("rst_len_l", 3'd4, 8'h00);

    // Idle bus, three bytes: done appears nine cycles after start is registered.
    setup(16'h0010, 16'h2000, 16'd3);
    for (int i = 0; i < 3; i++) push_copy(16'h0010 + 16'(i), 16'h2000 + 16'(i));
    wr(3'd6, 8'h01);
    for (int i = 0; i < 8; i++) cyc();
    chk("done_early", {31'd0, done_flag}, 32'd0);
    cyc();
    chk("done_at_9", {31'd0, done_flag}, 32'd1);
    chk("q_empty_1", exp_q.size(), 32'd0);
    rd("status_done", 3'd7, 8'h02);
    cfg_address = 8'h47;
    cfg_r_en = 1'b1;
    cyc();
    cfg_r_en = 1'b0;
    chk("read_other_holds", {24'd0, cfg_dout}, 32'h02);
    rd("src_after", 3'd0, 8'h13);
    clear_done();

    // CPU holds the bus for five cycles while a read is pending.
    setup(16'h0100, 16'h2100, 16'd2);
    push_copy(16'h0100, 16'h2100);
    push_copy(16'h0101, 16'h2101);
    wr(3'd6, 8'h01);
    cpu_bus_busy = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    cpu_bus_busy = 1'b0;
    cyc();
    chk("resume_read", exp_q.size(), 32'd3);
    wait_done("done_busy");
    chk("q_empty_2", exp_q.size(), 32'd0);
    clear_done();

    // CPU touches the bus during the read-data cycle; the latch still captures.
    setup(16'h0200, 16'h2200, 16'd1);
    push_copy(16'h0200, 16'h2200);
    wr(3'd6, 8'h01);
    cyc();
    cpu_bus_busy = 1'b1;
    cyc();
    cpu_bus_busy = 1'b0;
    wait_done("done_rwait");
    chk("q_empty_3", exp_q.size(), 32'd0);
    clear_done();

    // Zero-length start: no strobes, done next edge, set wins over clear.
    wr(3'd4, 8'h00); wr(3'd5, 8'h00);
    done_flag_clr = 1'b1;
    wr(3'd6, 8'h01);
    done_flag_clr = 1'b0;
    chk("len0_done", {31'd0, done_flag}, 32'd1);
    rd("len0_status", 3'd7, 8'h02);
    clear_done();

    // Source wrap, ignored start/LEN write while busy, abort during second write.
    setup(16'hFFFF, 16'h2300, 16'd2);
    push_copy(16'hFFFF, 16'h2300);
    push_copy(16'h0000, 16'h2301);
    wr(3'd6, 8'h01);
    cyc(); cyc(); cyc();
    wr(3'd6, 8'h01);
    wr(3'd4, 8'h55);
    wr(3'd6, 8'h02);
    chk("q_empty_abort", exp_q.size(), 32'd0);
    rd("abort_status", 3'd7, 8'h00);
    rd("abort_len_l", 3'd4, 8'h01);
    rd("abort_len_h", 3'd5, 8'h00);
    rd("abort_src_l", 3'd0, 8'h00);
    rd("abort_src_h", 3'd1, 8'h00);
    rd("abort_dst_l", 3'd2, 8'h01);
    rd("abort_dst_h", 3'd3, 8'h23);
    chk("abort_no_done", {31'd0, done_flag}, 32'd0);

    // Reset while a write strobe is on the bus.
    setup(16'h0300, 16'h2400, 16'd2);
    push(1'b0, 16'h0300);
    wr(3'd6, 8'h01);
    cyc(); cyc();
    chk("pre_rst_wen", {31'd0, dma_w_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_bus", {bus_grant, dma_r_en, dma_w_en, done_flag, dma_address, dma_dout, 4'd0},
        32'd0);
    chk("async_rst_cfg", {24'd0, cfg_dout}, 32'd0);
    cyc();
    rst = 1'b0;
    chk("q_empty_rst", exp_q.size(), 32'd0);
    rd("post_rst_src", 3'd0, 8'h00);
    rd("post_rst_dst_h", 3'd3, 8'h00);
    rd("post_rst_len", 3'd4, 8'h00);
    rd("post_rst_status", 3'd7, 8'h00);
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
